// File: rtl/game_round_sequencer.sv
// Round sequencer for the guess-the-quadrant VGA game: draws a random target,
// paces the show/select/compare/result phases and keeps a saturating win score.
module game_round_sequencer #(
  parameter int         NUM_QUADRANTS = 4,
  parameter int         SHOW_CYCLES   = 50_000_000,
  parameter int         RESULT_CYCLES = 100_000_000,
  parameter int         COMPARE_WAIT  = 3,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       confirm,
  input  logic       finish,
  input  logic       win,
  output logic [3:0] step,
  output logic [2:0] cuadranterandom,
  output logic [3:0] score,
  output logic       round_done
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DRAW    = 4'd1,
    S_SHOW    = 4'd2,
    S_SELECT  = 4'd6,
    S_COMPARE = 4'd7,
    S_WIN     = 4'd8,
    S_LOSE    = 4'd9
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [TW-1:0] timer;

  assign step = state;

  // One shared timer, cleared whenever the phase changes; the step register
  // itself is what the drawing logic and comparator decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      lfsr            <= LFSR_SEED;
      timer           <= '0;
      cuadranterandom <= '0;
      score           <= '0;
      round_done      <= 1'b0;
    end else begin
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      round_done <= 1'b0;
      timer      <= timer + TW'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_DRAW;
            timer <= '0;
          end
        end
        // Rejection sampling: out-of-range values are skipped while the LFSR runs on.
        S_DRAW: begin
          if ({1'b0, lfsr[2:0]} < 4'(NUM_QUADRANTS)) begin
            cuadranterandom <= lfsr[2:0];
            state           <= S_SHOW;
            timer           <= '0;
          end
        end
        S_SHOW: begin
          if (timer == TW'(SHOW_CYCLES - 1)) begin
            state <= S_SELECT;
            timer <= '0;
          end
        end
        S_SELECT: begin
          if (confirm) begin
            state <= S_COMPARE;
            timer <= '0;
          end
        end
        S_COMPARE: begin
          if (timer == TW'(COMPARE_WAIT - 1)) begin
            timer <= '0;
            if (win) begin
              state <= S_WIN;
              if (score != 4'd15) score <= score + 4'd1;
            end else begin
              state <= S_LOSE;
            end
          end
        end
        S_WIN, S_LOSE: begin
          if (timer == TW'(RESULT_CYCLES - 1)) begin
            state      <= S_IDLE;
            timer      <= '0;
            round_done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Randomized bench for game_round_sequencer: a round-level model predicts the
// phase timeline, drawn target, score and round_done pulse.
module tb_game_round_sequencer;

  localparam int NQ     = 4;
  localparam int SHOW   = 4;
  localparam int RESULT = 4;
  localparam int CW     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       confirm = 1'b0;
  logic       finish = 1'b0;
  logic       win = 1'b0;
  logic [3:0] step;
  logic [2:0] cuadranterandom;
  logic [3:0] score;
  logic       round_done;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_score = 0;
  logic [7:0] m_lfsr;

  game_round_sequencer #(
    .NUM_QUADRANTS(NQ),
    .SHOW_CYCLES(SHOW),
    .RESULT_CYCLES(RESULT),
    .COMPARE_WAIT(CW),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .confirm(confirm),
    .finish(finish),
    .win(win),
    .step(step),
    .cuadranterandom(cuadranterandom),
    .score(score),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  // Reference random source: polynomial x^8+x^6+x^5+x^4 as a tap mask.
  always @(posedge clk)
    m_lfsr <= rst ? 8'hA5 : {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (step !== 4'd0) begin n_bad++; $display("[TB] FAIL reset_step: got %0d want 0", step); end
    n_cmp++; if (score !== 4'd0) begin n_bad++; $display("[TB] FAIL reset_score: got %0d want 0", score); end
    n_cmp++; if (cuadranterandom !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_target: got %0d want 0", cuadranterandom); end
    n_cmp++; if (round_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %0b want 0", round_done); end
    exp_score = 0;
  endtask

  // mode: 0 win, 1 lose, 2 comparator fault (no flag), 3 both flags set
  task automatic test_round(input bit hold, input int mode, input bit stray);
    logic [2:0] tgt;
    logic [2:0] icu;
    logic [3:0] res_step;
    int guard;
    start = 1'b1;
    @(negedge clk);
    n_cmp++; if (step !== 4'd1) begin n_bad++; $display("[TB] FAIL enter_draw: got %0d want 1", step); end
    n_cmp++; if (round_done !== 1'b0) begin n_bad++; $display("[TB] FAIL done_cleared: got %0b want 0", round_done); end
    if (!hold) start = 1'b0;
    guard = 0;
    while (m_lfsr[2:0] >= NQ && guard < 64) begin
      @(negedge clk);
      guard++;
      n_cmp++; if (step !== 4'd1) begin n_bad++; $display("[TB] FAIL draw_reject: got %0d want 1", step); end
    end
    tgt = m_lfsr[2:0];
    @(negedge clk);
    n_cmp++; if (step !== 4'd2) begin n_bad++; $display("[TB] FAIL enter_show: got %0d want 2", step); end
    n_cmp++; if (cuadranterandom !== tgt) begin n_bad++; $display("[TB] FAIL target: got %0d want %0d", cuadranterandom, tgt); end
    for (int i = 1; i < SHOW; i++) begin
      if (stray && i == 1) confirm = 1'b1;
      @(negedge clk);
      confirm = 1'b0;
      n_cmp++; if (step !== 4'd2) begin n_bad++; $display("[TB] FAIL show_hold: got %0d want 2", step); end
    end
    @(negedge clk);
    n_cmp++; if (step !== 4'd6) begin n_bad++; $display("[TB] FAIL enter_select: got %0d want 6", step); end
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      n_cmp++; if (step !== 4'd6) begin n_bad++; $display("[TB] FAIL select_wait: got %0d want 6", step); end
    end
    confirm = 1'b1;
    @(negedge clk);
    confirm = 1'b0;
    n_cmp++; if (step !== 4'd7) begin n_bad++; $display("[TB] FAIL enter_compare: got %0d want 7", step); end
    icu = (mode == 1) ? 3'((int'(tgt) + 1 + $urandom_range(0, NQ - 2)) % NQ) : tgt;
    case (mode)
      0, 1: begin win = (icu == tgt); finish = (icu != tgt); end
      2: begin win = 1'b0; finish = 1'b0; end
      default: begin win = 1'b1; finish = 1'b1; end
    endcase
    for (int i = 1; i < CW; i++) begin
      @(negedge clk);
      n_cmp++; if (step !== 4'd7) begin n_bad++; $display("[TB] FAIL compare_hold: got %0d want 7", step); end
    end
    @(negedge clk);
    res_step = win ? 4'd8 : 4'd9;
    if (win && exp_score < 15) exp_score++;
    n_cmp++; if (step !== res_step) begin n_bad++; $display("[TB] FAIL result_step: got %0d want %0d", step, res_step); end
    n_cmp++; if (score !== 4'(exp_score)) begin n_bad++; $display("[TB] FAIL score: got %0d want %0d", score, exp_score); end
    for (int i = 1; i < RESULT; i++) begin
      @(negedge clk);
      n_cmp++; if (step !== res_step || round_done !== 1'b0) begin
        n_bad++; $display("[TB] FAIL result_hold: step %0d done %0b want %0d/0", step, round_done, res_step);
      end
    end
    @(negedge clk);
    win = 1'b0;
    finish = 1'b0;
    n_cmp++; if (step !== 4'd0 || round_done !== 1'b1) begin
      n_bad++; $display("[TB] FAIL round_end: step %0d done %0b want 0/1", step, round_done);
    end
    if (!hold) begin
      @(negedge clk);
      n_cmp++; if (step !== 4'd0 || round_done !== 1'b0) begin
        n_bad++; $display("[TB] FAIL idle_after: step %0d done %0b want 0/0", step, round_done);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    int guard;
    start = 1'b1;
    guard = 0;
    while (step !== 4'd2 && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    n_cmp++; if (step !== 4'd2) begin n_bad++; $display("[TB] FAIL reach_show: got %0d want 2", step); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_score = 0;
    n_cmp++; if (step !== 4'd0) begin n_bad++; $display("[TB] FAIL midreset_step: got %0d want 0", step); end
    n_cmp++; if (score !== 4'd0) begin n_bad++; $display("[TB] FAIL midreset_score: got %0d want 0", score); end
    n_cmp++; if (cuadranterandom !== 3'd0) begin n_bad++; $display("[TB] FAIL midreset_target: got %0d want 0", cuadranterandom); end
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 16; r++) test_round(1'b1, 0, 1'b0);
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (score !== 4'd15) begin n_bad++; $display("[TB] FAIL saturate: got %0d want 15", score); end
  endtask

  initial begin
    test_reset();
    test_round(1'b0, 0, 1'b1);
    test_round(1'b0, 1, 1'b0);
    test_round(1'b0, 2, 1'b0);
    test_round(1'b0, 3, 1'b0);
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      test_round(1'b0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    test_reset_mid_show();
    test_round(1'b0, 0, 1'b0);
    test_saturation();
    test_reset_mid_show();
    test_round(1'b0, 1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
- Drives one guess-the-quadrant round for the VGA game.
- Produces the 4-bit step code and the 3-bit random target quadrant that the selection comparator consumes.
- Reads back the comparator's finish/win outputs, holds the result screen for a fixed time, and keeps a win score.
- Sits between the user-input logic (start/confirm) and the VGA drawing logic, which decodes step to choose what to render.

Parameters:
- NUM_QUADRANTS, 4, number of valid quadrants; legal range 2..8; targets are 0..NUM_QUADRANTS-1.
- SHOW_CYCLES, 50_000_000, clocks the target is displayed during step 2.
- RESULT_CYCLES, 100_000_000, clocks the result is displayed during steps 8/9.
- COMPARE_WAIT, 3, clocks step is held at 7 before sampling win/finish; minimum 2.
- LFSR_SEED, 8'hA5, non-zero reset value of the LFSR.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level; begins a round when sampled high in step 0.
- confirm  in  1  single-cycle pulse; user has committed the icuadrante selection.
- finish  in  1  comparator lose flag.
- win  in  1  comparator win flag.
- step  out  4  current round phase.
- cuadranterandom  out  3  target quadrant.
- score  out  4  saturating win count.
- round_done  out  1  one-cycle pulse when a round returns to step 0.

Behaviour:
- Reset (rst sampled high at a clock edge, any state, including mid-round):
  - step=0, cuadranterandom=0, score=0, round_done=0.
  - LFSR=LFSR_SEED; timers cleared.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every clock except during reset. It never reaches zero.
- Steps (register encoding):
  - 0 IDLE: if start=1, go to 1 next cycle.
  - 1 DRAW: if LFSR[2:0] < NUM_QUADRANTS, latch cuadranterandom=LFSR[2:0] and go to 2. Otherwise stay in 1 (rejection sampling; the LFSR keeps advancing). cuadranterandom is stable from entry to step 2 until the next DRAW latch.
  - 2 SHOW: timer counts SHOW_CYCLES clocks, then go to 6. Steps 3–5 are reserved and never produced.
  - 6 SELECT: wait for confirm=1, then go to 7. confirm in any other step is ignored.
  - 7 COMPARE: hold exactly COMPARE_WAIT clocks. In the last clock, sample win and finish:
    - win=1: go to 8 and increment score, saturating at 15.
    - otherwise finish=1: go to 9.
    - neither set (comparator fault): go to 9 and treat as a loss.
    - both set: win has priority.
  - 8 WIN / 9 LOSE: timer counts RESULT_CYCLES clocks, then go to 0 and assert round_done for exactly the cycle step becomes 0.
  - Codes 10–15 are unreachable. If encountered, go to 0 next cycle with no round_done.
- Timers: one shared counter, cleared on every step change. Width is ceil(log2(max(SHOW_CYCLES, RESULT_CYCLES)))+1.
- start held high continuously: after a round returns to 0, the next round begins one cycle later (step 0 lasts one cycle).
- The comparator needs step=0 between rounds to clear its flags. The sequencer always passes through 0, so stale win/finish from a previous round are never sampled.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Reset mid-SHOW: force step=2, assert rst one cycle -> next cycle step=0, score=0, cuadranterandom=0, LFSR=8'hA5.
- Rejection: NUM_QUADRANTS=4, force LFSR[2:0]=5 on entry to step 1 -> step stays 1 until LFSR[2:0]<4; latched cuadranterandom equals that LFSR[2:0] value.
- Win round (SHOW_CYCLES=4, RESULT_CYCLES=4, COMPARE_WAIT=3, comparator model with icuadrante=cuadranterandom):
  - step sequence 0,1,2×4,6…,7×3,8×4,0.
  - score 0→1; round_done pulses once.
- Lose round: icuadrante≠cuadranterandom -> step goes 7→9; score unchanged; round_done pulses after 4 cycles in 9.
- Saturation/continuous start: 16 consecutive wins with start held high -> score=15 after win 15 and stays 15 after win 16; step 0 lasts one cycle between rounds.
- Ignored confirm / fault: confirm pulsed during step 2 -> no effect, step still advances to 6. In step 7 with win=finish=0 -> step goes to 9.
